// File: rtl/spi_ctrl_pkg.sv
// Shared FSM state encoding and SPI command codes for the SPI slave controller.
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_e;

    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

endpackage

// File: rtl/spi_rx_shifter.sv
// Serial-in MSB-first frame shifter with bit counter; saturates once a full
// DATA_W+2 bit frame is held so trailing MOSI bits are discarded.
module spi_rx_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              shiftEn_i,
    input  logic              mosi_i,
    output logic [DATA_W+1:0] frameNext_o,
    output logic              lastBit_o
);

    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);

    logic [FRAME_W-1:0] frame_q;
    logic [CNT_W-1:0]   count_q;
    logic               full;

    assign full        = (count_q == CNT_FULL);
    assign frameNext_o = {frame_q[FRAME_W-2:0], mosi_i};
    assign lastBit_o   = (count_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            frame_q <= '0;
            count_q <= '0;
        end else if (shiftEn_i && !full) begin
            frame_q <= frameNext_o;
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end for a single-port RAM: decodes 2-bit command frames,
// strobes complete frames to the RAM and shifts read bytes back out on MISO.
module spi_slave_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam int TXC_W = $clog2(DATA_W + 1);

    state_e              state_q, state_d;
    logic                rdAddrFlag_q, rdAddrFlag_d;
    logic [DATA_W+1:0]   rxData_q, rxData_d;
    logic                rxValid_q, rxValid_d;
    logic                txWait_q, txWait_d;
    logic [DATA_W-1:0]   txShift_q, txShift_d;
    logic [TXC_W-1:0]    txCnt_q, txCnt_d;

    logic                shiftEn;
    logic                clearRx;
    logic                lastBit;
    logic                frameDone;
    logic [DATA_W+1:0]   frameNext;

    spi_rx_shifter #(.DATA_W(DATA_W)) u_rx_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (clearRx),
        .shiftEn_i  (shiftEn),
        .mosi_i     (MOSI),
        .frameNext_o(frameNext),
        .lastBit_o  (lastBit)
    );

    always_comb begin
        state_d      = state_q;
        rdAddrFlag_d = rdAddrFlag_q;
        rxData_d     = rxData_q;
        rxValid_d    = 1'b0;
        txWait_d     = txWait_q;
        txShift_d    = txShift_q;
        txCnt_d      = txCnt_q;
        shiftEn      = 1'b0;
        clearRx      = 1'b0;
        frameDone    = 1'b0;

        case (state_q)
            IDLE: begin
                clearRx = 1'b1;
                if (!SS_n) state_d = CHK_CMD;
            end
            CHK_CMD: begin
                shiftEn = 1'b1;
                if (MOSI == RD_ADDR[1]) state_d = rdAddrFlag_q ? READ_DATA : READ_ADD;
                else                    state_d = WRITE;
            end
            WRITE, READ_ADD: shiftEn = 1'b1;
            READ_DATA: begin
                shiftEn = 1'b1;
                // The RAM sees the frame during the rx_valid cycle, so only answer after it.
                if (txWait_q && tx_valid) begin
                    txShift_d = tx_data;
                    txCnt_d   = TXC_W'(DATA_W);
                    txWait_d  = 1'b0;
                end else if (txCnt_q != '0) begin
                    txShift_d = {txShift_q[DATA_W-2:0], 1'b0};
                    txCnt_d   = txCnt_q - 1'b1;
                end
                if (rxValid_q) txWait_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        frameDone = shiftEn && lastBit;
        if (frameDone) begin
            rxValid_d = 1'b1;
            rxData_d  = frameNext;
            if (state_q == READ_ADD)       rdAddrFlag_d = 1'b1;
            else if (state_q == READ_DATA) rdAddrFlag_d = 1'b0;
        end

        // Deselect wins over everything, including a frame finishing this cycle.
        if (SS_n) begin
            state_d      = IDLE;
            clearRx      = 1'b1;
            shiftEn      = 1'b0;
            rxValid_d    = 1'b0;
            rxData_d     = rxData_q;
            rdAddrFlag_d = rdAddrFlag_q;
            txWait_d     = 1'b0;
            txShift_d    = '0;
            txCnt_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rdAddrFlag_q <= 1'b0;
            rxData_q     <= '0;
            rxValid_q    <= 1'b0;
            txWait_q     <= 1'b0;
            txShift_q    <= '0;
            txCnt_q      <= '0;
        end else begin
            state_q      <= state_d;
            rdAddrFlag_q <= rdAddrFlag_d;
            rxData_q     <= rxData_d;
            rxValid_q    <= rxValid_d;
            txWait_q     <= txWait_d;
            txShift_q    <= txShift_d;
            txCnt_q      <= txCnt_d;
        end
    end

    assign rx_data  = rxData_q;
    assign rx_valid = rxValid_q;
    assign MISO     = (txCnt_q != '0) && txShift_q[DATA_W-1];

endmodule
